// File: rtl/wb_apb_bridge.sv
// Wishbone B4 slave (classic or pipelined) to APB4 master bridge.
// One Wishbone request becomes one APB SETUP/ACCESS transfer. The APB
// completion is returned to the master as a single ack_o or err_o pulse.
// Every output is driven straight from a flop.
module wb_apb_bridge #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8,
    parameter int TIMEOUT    = 16,
    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Wishbone slave side
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  we_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o,
    // APB master side
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [SEL_WIDTH-1:0]  pstrb_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    // Wide enough to hold TIMEOUT-1, the last wait count before aborting.
    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  wait_cnt_q;
    logic                  abandon_q;   // master dropped cyc_i mid-transfer
    logic                  abandon;

    logic [DATA_WIDTH-1:0] dat_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  stall_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [SEL_WIDTH-1:0]  pstrb_q;

    // The response is suppressed if cyc_i was low on any SETUP/ACCESS edge,
    // including the completing edge itself.
    assign abandon = abandon_q | ~cyc_i;

    // Request capture, APB sequencing and Wishbone response in one FSM.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous here, so it sits inside the clocked
        // branch and only takes effect on an edge; all state uses <= so
        // every flop samples the pre-edge values of its neighbours.
        if (rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            abandon_q  <= 1'b0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
            paddr_q    <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
        end else begin
            // Response strobes are single-cycle pulses by default.
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    stall_q   <= 1'b0;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    abandon_q <= 1'b0;
                    if (cyc_i && stb_i) begin
                        stall_q    <= 1'b1;
                        wait_cnt_q <= '0;
                        if (we_i && (sel_i == '0)) begin
                            // A write with no byte lanes never reaches APB.
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            paddr_q  <= adr_i;
                            pwrite_q <= we_i;
                            pwdata_q <= dat_i;
                            pstrb_q  <= we_i ? sel_i : '0;
                            psel_q   <= 1'b1;
                            state_q  <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    abandon_q <= abandon;
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    if (pready_i || (wait_cnt_q == CNT_LAST)) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= RESP;
                        if (!abandon) begin
                            if (pready_i && !pslverr_i) begin
                                ack_q <= 1'b1;
                                if (!pwrite_q) begin
                                    dat_q <= prdata_i;
                                end
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                        abandon_q  <= abandon;
                    end
                end

                RESP: begin
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign stall_o   = stall_q;
    assign paddr_o   = paddr_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_wb_apb_bridge.sv
// Directed bench for wb_apb_bridge: inputs change #1 after each rising edge,
// outputs are sampled at that same point, well away from the next edge.
module tb_wb_apb_bridge;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_i;
    logic          we_i;
    logic          cyc_i;
    logic          stb_i;
    logic          ack_o;
    logic          err_o;
    logic          stall_o;
    logic [AW-1:0] paddr_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    int vectors = 0;
    int miscompares = 0;

    wb_apb_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .GRANULE   (8),
        .TIMEOUT   (16)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .dat_o    (dat_o),
        .sel_i    (sel_i),
        .we_i     (we_i),
        .cyc_i    (cyc_i),
        .stb_i    (stb_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .stall_o  (stall_o),
        .paddr_o  (paddr_o),
        .psel_o   (psel_o),
        .penable_o(penable_o),
        .pwrite_o (pwrite_o),
        .pwdata_o (pwdata_o),
        .pstrb_o  (pstrb_o),
        .prdata_i (prdata_i),
        .pready_i (pready_i),
        .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] bits;
        bits = {dat_o, 1'b0, ack_o, err_o, stall_o, psel_o, penable_o, pwrite_o, pstrb_o};
        check({tag, " ctl/dat"}, bits, 64'h0);
        check({tag, " paddr"}, 64'(paddr_o), 64'h0);
        check({tag, " pwdata"}, 64'(pwdata_o), 64'h0);
    endtask

    initial begin
        int pen_cycles;
        int err_pulses;
        int ack_pulses;
        logic psel_at_err;

        rst_i = 1'b1; adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;

        // Reset state
        step(); step();
        check_all_zero("reset");
        rst_i = 1'b0;
        step();

        // Classic write, zero-wait APB
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0010;
        sel_i = 4'hF; dat_i = 32'hDEADBEEF; pready_i = 1'b1;
        step();                                  // cycle N+1: SETUP
        check("wr setup psel", psel_o, 1);
        check("wr setup penable", penable_o, 0);
        check("wr paddr", paddr_o, 16'h0010);
        check("wr pwdata", pwdata_o, 32'hDEADBEEF);
        check("wr pstrb", pstrb_o, 4'hF);
        check("wr pwrite", pwrite_o, 1);
        check("wr setup stall", stall_o, 1);
        check("wr setup ack", ack_o, 0);
        step();                                  // N+2: ACCESS
        check("wr access psel/penable", {psel_o, penable_o}, 2'b11);
        check("wr access paddr held", paddr_o, 16'h0010);
        check("wr access ack", ack_o, 0);
        step();                                  // N+3: RESP
        check("wr resp ack/err", {ack_o, err_o}, 2'b10);
        check("wr resp psel/penable", {psel_o, penable_o}, 2'b00);
        check("wr resp stall", stall_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        check("wr idle ack/stall", {ack_o, err_o, stall_o}, 3'b000);

        // Pipelined read with three wait cycles
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'h0020; sel_i = 4'hF;
        pready_i = 1'b0; prdata_i = 32'h12345678;
        step();                                  // N+1: SETUP
        stb_i = 1'b0;
        check("rd pstrb", pstrb_o, 4'h0);
        check("rd pwrite", pwrite_o, 0);
        check("rd paddr", paddr_o, 16'h0020);
        check("rd setup stall", stall_o, 1);
        for (int i = 0; i < 4; i++) begin        // N+2 .. N+5: ACCESS
            step();
            check("rd access penable", penable_o, 1);
            check("rd access stall", stall_o, 1);
            check("rd access ack", ack_o, 0);
        end
        pready_i = 1'b1;
        step();                                  // N+6: RESP
        check("rd ack", {ack_o, err_o}, 2'b10);
        check("rd dat_o", dat_o, 32'h12345678);
        check("rd resp stall", stall_o, 1);
        cyc_i = 1'b0;
        prdata_i = 32'h0BADF00D;
        step();
        check("rd idle ack/stall", {ack_o, stall_o}, 2'b00);
        check("rd dat_o held", dat_o, 32'h12345678);

        // Read answered with pslverr
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 16'h0024;
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hCAFEF00D;
        step(); stb_i = 1'b0;
        step();
        step();
        check("slverr ack/err", {ack_o, err_o}, 2'b01);
        check("slverr dat_o kept", dat_o, 32'h12345678);
        cyc_i = 1'b0; pslverr_i = 1'b0;
        step();
        check("slverr err cleared", err_o, 0);

        // ACCESS timeout with pready stuck low
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 16'h0030;
        sel_i = 4'h3; dat_i = 32'h00000055; pready_i = 1'b0;
        step(); stb_i = 1'b0;
        check("to pstrb", pstrb_o, 4'h3);
        pen_cycles = 0; err_pulses = 0; ack_pulses = 0; psel_at_err = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (penable_o) pen_cycles++;
            if (ack_o) ack_pulses++;
            if (err_o) begin
                err_pulses++;
                psel_at_err = psel_o;
            end
        end
        check("to penable cycles", 64'(pen_cycles), 64'd16);
        check("to err pulses", 64'(err_pulses), 64'd1);
        check("to ack pulses", 64'(ack_pulses), 64'd0);
        check("to psel at err", psel_at_err, 0);
        cyc_i = 1'b0;
        step();

        // Write with no byte selects: immediate error, no APB transfer
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'h0; adr_i = 16'h0044;
        pready_i = 1'b1;
        step();
        check("sel0 err/ack", {err_o, ack_o}, 2'b10);
        check("sel0 psel", psel_o, 0);
        check("sel0 stall", stall_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        check("sel0 after err/psel/stall", {err_o, psel_o, stall_o}, 3'b000);

        // cyc_i dropped during ACCESS on a read: no response, dat_o untouched
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; sel_i = 4'hF; adr_i = 16'h0050;
        pready_i = 1'b0; prdata_i = 32'hA5A5A5A5;
        step(); stb_i = 1'b0;                    // SETUP
        step();                                  // ACCESS
        check("abort access psel/penable", {psel_o, penable_o}, 2'b11);
        cyc_i = 1'b0; pready_i = 1'b1;
        step();                                  // RESP, suppressed
        check("abort ack/err", {ack_o, err_o}, 2'b00);
        check("abort psel", psel_o, 0);
        check("abort dat_o kept", dat_o, 32'h12345678);
        step();
        check("abort idle ack/err", {ack_o, err_o}, 2'b00);

        // Reset asserted for two edges during ACCESS
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; adr_i = 16'h0060;
        dat_i = 32'h11223344; pready_i = 1'b0;
        step(); stb_i = 1'b0;
        step();
        check("rst pre access penable", penable_o, 1);
        rst_i = 1'b1;
        step();
        check_all_zero("rst edge1");
        step();
        check_all_zero("rst edge2");
        rst_i = 1'b0; pready_i = 1'b1;
        step();
        check("rst after ack/err/psel", {ack_o, err_o, psel_o, penable_o}, 4'b0000);
        cyc_i = 1'b0;
        step();

        // stb_i held through RESP is taken on the following IDLE edge only
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; adr_i = 16'h0070;
        dat_i = 32'h0000BEEF; pready_i = 1'b1;
        step();                                  // SETUP
        step();                                  // ACCESS
        step();                                  // RESP
        check("b2b ack", ack_o, 1);
        step();                                  // IDLE, not yet accepted
        check("b2b idle psel/stall", {psel_o, stall_o, ack_o}, 3'b000);
        step();                                  // second SETUP
        check("b2b second setup", {psel_o, penable_o, stall_o}, 3'b101);
        stb_i = 1'b0;
        step(); step();
        check("b2b second ack", ack_o, 1);
        cyc_i = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
